pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
//
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline. Drives en/Flush of the
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazards:
//   - data-memory wait,
//   - multi-cycle MDU (mul/div) occupancy in EX,
//   - load-use.
//  Squashes wrong-path instructions on a taken branch/jump, and keeps stall/flush
//  performance counters. Sits beside the datapath; the datapath registers consume
//  its outputs directly.
//
// PARAMETERS
//  REG_W  5   register-index width (rs1/rs2/rd)
//  CNT_W  32  width of the performance counters (saturating)
//
// PORTS
//  CLK            in   1      clock, rising edge
//  RST            in   1      reset; one clock; reset is synchronous and active-high
//  id_rs1         in   REG_W  rs1 of the instruction in ID
//  id_rs2         in   REG_W  rs2 of the instruction in ID
//  id_uses_rs2    in   1      ID instruction reads rs2
//  ex_rd          in   REG_W  rd of the instruction in EX
//  ex_mem_read    in   1      EX instruction is a load
//  ex_is_mdu      in   1      EX instruction is an MDU op
//  ex_redirect    in   1      taken branch/jump resolved in EX
//  mem_req        in   1      MEM-stage data-memory access active
//  mem_ready      in   1      data memory completes this cycle
//  mdu_done       in   1      MDU result valid (1-cycle pulse)
//  mdu_start      out  1      1-cycle MDU launch pulse
//  pc_en          out  1      PC write enable
//  ifid_en        out  1      IF/ID enable
//  ifid_flush     out  1      IF/ID flush
//  idex_en        out  1      ID/EX enable
//  idex_flush     out  1      ID/EX flush
//  exmem_en       out  1      EX/MEM enable
//  exmem_flush    out  1      EX/MEM flush
//  memwb_en       out  1      MEM/WB enable
//  memwb_flush    out  1      MEM/WB flush
//  stall_cnt      out  CNT_W  cycles with pc_en=0
//  flush_cnt      out  CNT_W  redirect events taken
//
// BEHAVIOUR
//  State and counters
//   - FSM states: RUN, MDU_BUSY. Flag done_pend.
//   - RST: state=RUN, done_pend=0, counters=0, mdu_start=0.
//   - While RST=1: all *_en=0, all *_flush=1.
//   - Reset in MDU_BUSY abandons the op. The MDU shares RST.
//  Combinational stall terms (priority high -> low)
//   - mem_stall = mem_req & ~mem_ready
//   - mdu_stall = ex_is_mdu & ~(state==MDU_BUSY & (mdu_done|done_pend))
//   - lu_stall  = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))
//  Output actions
//   - mem_stall: all en=0 except memwb_en=1; memwb_flush=1 (bubble into WB).
//     All other terms are ignored this cycle.
//   - mdu_stall: pc/ifid/idex en=0; exmem_en=1, exmem_flush=1 (bubble). MEM/WB run.
//   - ex_redirect (no mem/mdu stall): ifid_flush=1, idex_flush=1; all en=1.
//     Redirect overrides lu_stall, because the ID instruction is wrong-path.
//     Counts flush_cnt+1.
//   - lu_stall: pc_en=0, ifid_en=0, idex_flush=1. Later stages run.
//     Latency: 1 bubble.
//   - Otherwise: all en=1, all flush=0.
//  MDU sequencing
//   - RUN & ex_is_mdu & ~mem_stall -> mdu_start=1 (registered, one cycle), state
//     -> MDU_BUSY. ex_is_mdu must not retrigger.
//   - MDU_BUSY & mdu_done & mem_stall -> done_pend=1 (the result is held in the MDU).
//   - MDU_BUSY & (mdu_done|done_pend) & ~mem_stall -> EX released this cycle;
//     state -> RUN; done_pend=0.
//   - mdu_done in RUN is ignored.
//  Counters
//   - stall_cnt +1 each non-reset cycle with pc_en=0.
//   - Both counters saturate at all-ones; no wrap.
//
// TESTING
//  1. lw x5 in EX, ID reads x5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1;
//     next cycle all en=1; stall_cnt=1.
//  2. Load to x0 followed by an x0 reader -> no stall.
//  3. Same as 1 with ex_redirect=1 -> ifid_flush=idex_flush=1, pc_en=1,
//     flush_cnt=1, stall_cnt=0.
//  4. MDU op, mdu_done 4 cycles after mdu_start ->
//     - a single mdu_start pulse;
//     - exmem_flush high for 4 cycles;
//     - release on the done cycle;
//     - state RUN.
//  5. mdu_done arrives during mem_stall (mem_ready low 3 cycles) ->
//     - done_pend=1;
//     - memwb_flush high for 3 cycles;
//     - EX released on the first cycle with mem_ready=1;
//     - no second mdu_start.
//  6. RST asserted in MDU_BUSY, then deasserted ->
//     - outputs flush during reset;
//     - state RUN;
//     - counters 0;
//     - a fresh MDU op restarts with a new mdu_start.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Drives pipeline-register enables and flushes, sequences the MDU, and keeps stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_mdu,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             mdu_done,
  output logic             mdu_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t state;
  logic   done_pend;
  logic   mem_stall;
  logic   mdu_finish;
  logic   mdu_stall;
  logic   lu_stall;
  logic   redirect_take;

  assign mem_stall  = mem_req & ~mem_ready;
  assign mdu_finish = (state == MDU_BUSY) & (mdu_done | done_pend);
  assign mdu_stall  = ex_is_mdu & ~mdu_finish;
  assign lu_stall   = ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign redirect_take = ~RST & ~mem_stall & ~mdu_stall & ex_redirect;

  // Highest-priority hazard wins; a redirect beats load-use because the ID instruction is wrong-path.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    if (RST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mdu_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // MDU sequencing: a finish that lands during a memory wait is remembered in done_pend.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      done_pend <= 1'b0;
      mdu_start <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mdu_start <= 1'b0;
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_take && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (ex_is_mdu && !mem_stall) begin
            mdu_start <= 1'b1;
            state     <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if ((mdu_done || done_pend) && !mem_stall) begin
            state     <= RUN;
            done_pend <= 1'b0;
          end else if (mdu_done && mem_stall) begin
            done_pend <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: an action-table model checked every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs2, ex_mem_read, ex_is_mdu, ex_redirect;
  logic             mem_req, mem_ready, mdu_done;
  logic             mdu_start, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, memwb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;
  int tally_start = 0;
  int tally_exf = 0;
  int tally_mwf = 0;
  bit check_on = 1'b0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mdu(ex_is_mdu),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .mdu_done(mdu_done), .mdu_start(mdu_start), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Model: which single action the controller takes this cycle, and what each action drives.
  typedef enum {A_RESET, A_MEMW, A_MDUW, A_REDIR, A_LOADUSE, A_FLOW} act_t;

  bit m_busy = 1'b0;
  bit m_pend = 1'b0;
  bit m_start = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic bit mem_wait();
    return mem_req && !mem_ready;
  endfunction

  function automatic act_t classify();
    bit finishing, load_use;
    finishing = m_busy && (mdu_done || m_pend);
    load_use  = ex_mem_read && (ex_rd != 0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    if (RST)                         return A_RESET;
    if (mem_wait())                  return A_MEMW;
    if (ex_is_mdu && !finishing)     return A_MDUW;
    if (ex_redirect)                 return A_REDIR;
    if (load_use)                    return A_LOADUSE;
    return A_FLOW;
  endfunction

  // Bits: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush
  function automatic logic [8:0] action_vec(input act_t a);
    case (a)
      A_RESET:   return 9'b001010101;
      A_MEMW:    return 9'b000000011;
      A_MDUW:    return 9'b000001110;
      A_REDIR:   return 9'b111111010;
      A_LOADUSE: return 9'b000111010;
      default:   return 9'b110101010;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    act_t a;
    bit start_now;
    if (RST) begin
      m_busy = 1'b0; m_pend = 1'b0; m_start = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else begin
      a = classify();
      if (action_vec(a)[8] == 1'b0 && m_scnt < CNT_MAX) m_scnt++;
      if (a == A_REDIR && m_fcnt < CNT_MAX) m_fcnt++;
      start_now = !m_busy && ex_is_mdu && !mem_wait();
      if (m_busy) begin
        if ((mdu_done || m_pend) && !mem_wait()) begin
          m_busy = 1'b0; m_pend = 1'b0;
        end else if (mdu_done && mem_wait()) begin
          m_pend = 1'b1;
        end
      end else if (start_now) begin
        m_busy = 1'b1;
      end
      m_start = start_now;
    end
  end

  always @(negedge CLK) begin
    if (check_on) begin
      checkOutput("ctrl_vec",
                  {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, memwb_flush},
                  action_vec(classify()));
      checkOutput("mdu_start", mdu_start, m_start);
      checkOutput("stall_cnt", stall_cnt, m_scnt);
      checkOutput("flush_cnt", flush_cnt, m_fcnt);
      if (mdu_start)   tally_start++;
      if (exmem_flush) tally_exf++;
      if (memwb_flush) tally_mwf++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setIdle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_is_mdu = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1; mdu_done = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic doReset();
    setIdle();
    RST = 1'b1;
    step();
    RST = 1'b0;
    tally_start = 0; tally_exf = 0; tally_mwf = 0;
  endtask

  initial begin
    RST = 1'b1;
    setIdle();
    step();
    check_on = 1'b1;
    RST = 1'b0;
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    checkOutput("reset_mdu_start", mdu_start, 0);

    // Load-use on rs1: one bubble, then free flow.
    doReset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    checkOutput("t1_pc_en", pc_en, 0);
    checkOutput("t1_idex_flush", idex_flush, 1);
    step();
    setIdle();
    #1;
    checkOutput("t1_pc_en_after", pc_en, 1);
    checkOutput("t1_stall_cnt", stall_cnt, 1);
    applyStimulus(1);

    // Load to x0 never stalls; rs2 only matters when it is used.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checkOutput("t2_x0_pc_en", pc_en, 1);
    step();
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    checkOutput("t2_rs2_pc_en", pc_en, 0);
    step();
    id_uses_rs2 = 1'b0;
    #1;
    checkOutput("t2_rs2_unused_pc_en", pc_en, 1);
    step();
    setIdle();

    // Redirect overrides load-use.
    doReset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
    #1;
    checkOutput("t3_ifid_flush", ifid_flush, 1);
    checkOutput("t3_pc_en", pc_en, 1);
    step();
    setIdle();
    #1;
    checkOutput("t3_flush_cnt", flush_cnt, 1);
    checkOutput("t3_stall_cnt", stall_cnt, 0);
    applyStimulus(1);

    // MDU op finishing on the fourth stalled cycle.
    doReset();
    ex_is_mdu = 1'b1;
    applyStimulus(4);
    mdu_done = 1'b1;
    #1;
    checkOutput("t4_release_pc_en", pc_en, 1);
    step();
    setIdle();
    checkOutput("t4_start_pulses", tally_start, 1);
    checkOutput("t4_exmem_flush_cycles", tally_exf, 4);
    checkOutput("t4_stall_cnt", stall_cnt, 4);
    applyStimulus(2);

    // MDU finish during a three-cycle memory wait.
    doReset();
    ex_is_mdu = 1'b1;
    applyStimulus(2);
    mem_req = 1'b1; mem_ready = 1'b0; mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    applyStimulus(2);
    mem_ready = 1'b1;
    #1;
    checkOutput("t5_release_exmem_flush", exmem_flush, 0);
    checkOutput("t5_release_pc_en", pc_en, 1);
    step();
    setIdle();
    checkOutput("t5_memwb_flush_cycles", tally_mwf, 3);
    checkOutput("t5_start_pulses", tally_start, 1);
    checkOutput("t5_stall_cnt", stall_cnt, 5);
    applyStimulus(2);

    // Reset while the MDU is busy, then a fresh op.
    doReset();
    ex_is_mdu = 1'b1;
    applyStimulus(3);
    RST = 1'b1;
    #1;
    checkOutput("t6_rst_pc_en", pc_en, 0);
    checkOutput("t6_rst_memwb_flush", memwb_flush, 1);
    step();
    RST = 1'b0;
    checkOutput("t6_stall_cnt", stall_cnt, 0);
    checkOutput("t6_flush_cnt", flush_cnt, 0);
    step();
    checkOutput("t6_restart_pulse", mdu_start, 1);
    applyStimulus(2);
    mdu_done = 1'b1;
    step();
    setIdle();
    applyStimulus(1);

    // MDU in EX under a memory wait does not launch until memory is ready.
    doReset();
    ex_is_mdu = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    applyStimulus(2);
    checkOutput("t7_no_start_in_wait", mdu_start, 0);
    mem_ready = 1'b1;
    step();
    checkOutput("t7_start_after_wait", mdu_start, 1);
    mdu_done = 1'b1;
    step();
    setIdle();
    mdu_done = 1'b1;
    applyStimulus(1);
    mdu_done = 1'b0;
    applyStimulus(1);

    // Counter saturation and redirect suppression under memory wait.
    doReset();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    applyStimulus(20);
    checkOutput("t8_stall_sat", stall_cnt, CNT_MAX);
    setIdle();
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    applyStimulus(2);
    checkOutput("t8_redirect_in_wait", flush_cnt, 0);
    mem_ready = 1'b1;
    applyStimulus(20);
    checkOutput("t8_flush_sat", flush_cnt, CNT_MAX);
    setIdle();
    applyStimulus(2);

    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
